debounce_filter: RTL
====================

// Module: debounce_filter
// PURPOSE
//   Per-bit glitch/bounce filter placed directly after the 2-flop synchronizer
//   on slow external inputs (buttons, switches, strap pins). Consumes already
//   synchronized bits and drives a filtered level per bit. A bit takes a new
//   level only after the input has held it for P_STABLE_CNT consecutive cycles.
//   Emits single-cycle rise/fall pulses for downstream control logic.
// PARAMETERS
//   P_DATA_W      8      number of independent input bits
//   P_STABLE_CNT  50000  consecutive differing samples needed to flip a bit (>=1)
//   P_CNT_W       16     counter width; must satisfy 2**P_CNT_W > P_STABLE_CNT-1
//   P_RST_VAL     0      [P_DATA_W-1:0] reset value of o_data
// PORTS
//   clk        in   1         single clock; all logic on posedge
//   rst_n      in   1         asynchronous active-low reset
//   i_data     in   P_DATA_W  synchronized inputs (no further CDC done here)
//   o_data     out  P_DATA_W  debounced level, registered
//   o_rise     out  P_DATA_W  1-cycle pulse when o_data[k] goes 0->1
//   o_fall     out  P_DATA_W  1-cycle pulse when o_data[k] goes 1->0
//   o_evt      out  P_DATA_W  sticky event flags      (DEBOUNCE_EVENT_EN only)
//   i_evt_clr  in   P_DATA_W  write-1-to-clear o_evt  (DEBOUNCE_EVENT_EN only)
//   o_irq      out  1         |o_evt, registered      (DEBOUNCE_EVENT_EN only)
// BEHAVIOUR
//   - Reset (async assert, sync-by-clk deassert upstream): o_data=P_RST_VAL,
//     o_rise=o_fall=0, all counters=0, all cells IDLE, o_evt=0, o_irq=0.
//     No rise/fall pulse is generated by reset assertion or release.
//   - Each bit k is an independent 2-state FSM with counter cnt[k]:
//     IDLE : i_data[k]==o_data[k]; cnt=0. If i_data[k]!=o_data[k]:
//            if P_STABLE_CNT==1 flip now, else cnt<=1, go COUNT.
//     COUNT: if i_data[k]==o_data[k]: cnt<=0, go IDLE (glitch rejected).
//            elif cnt==P_STABLE_CNT-1: o_data[k]<=~o_data[k], cnt<=0, go IDLE.
//            else cnt<=cnt+1.
//   - Latency: o_data[k] changes on the clock edge that registers the
//     P_STABLE_CNT-th consecutive differing sample; P_STABLE_CNT=1 = 1 reg delay.
//   - o_rise/o_fall asserted in the same cycle o_data changes, exactly 1 cycle;
//     never both high for one bit. Multiple bits may pulse in the same cycle.
//   - Bounce during COUNT restarts counting from 0; no partial credit kept.
//   - Counter never exceeds P_STABLE_CNT-1; no wrap-around possible.
//   - Reset mid-count discards the count; o_data returns to P_RST_VAL.
// CONFIGURATION
//   Macro DEBOUNCE_EVENT_EN:
//   - defined  : o_evt[k] set on o_rise[k]|o_fall[k]; cleared by i_evt_clr[k];
//                set and clear in same cycle -> set wins (o_evt stays 1).
//                o_irq = registered OR of o_evt (1 cycle after o_evt).
//   - undefined: o_evt, i_evt_clr, o_irq ports and logic absent; rest identical.
// STRUCTURE
//   - Shared include debounce_defs.vh: FSM state localparams
//     (ST_IDLE=1'b0, ST_COUNT=1'b1) and the P_CNT_W sizing check macro.
//   - Sub-module debounce_cell: one bit (FSM, counter, level, rise/fall);
//     top instantiates P_DATA_W copies via generate and adds event/irq logic.
//   - Elaboration check: P_STABLE_CNT>=1 and P_STABLE_CNT-1 < 2**P_CNT_W.
// TESTING  (P_DATA_W=2, P_STABLE_CNT=4, P_RST_VAL=2'b00)
//   1 Reset: i_data=2'b11 held 2 cycles (cnt=2), assert rst_n=0 -> o_data=00,
//     pulses 0 immediately; release -> o_data=11 after 4 further edges.
//   2 Clean step: i_data[0] 0->1 held -> o_data[0]=1 on 4th edge, o_rise[0]=1
//     exactly that cycle, o_fall=0.
//   3 Glitch: i_data[0]=1 for 3 cycles then 0 -> o_data stays 00, no pulses.
//   4 Bounce: i_data[0] seq 1,0,1,1,1,1 -> o_data[0] rises on 4th edge after
//     last 0; single o_rise pulse.
//   5 Parallel: from o_data=01, i_data=10 same cycle -> o_rise[1] and o_fall[0]
//     both high in same cycle, o_data=10.
//   6 DEBOUNCE_EVENT_EN: edge sets o_evt[0], o_irq next cycle; i_evt_clr[0]
//     coincident with new edge -> o_evt[0] stays 1; lone clear -> 0, o_irq->0.

Source files
------------

// File: rtl/debounce_filter_pkg.sv
// -----------------------------------------------------------------------------
// debounce_filter_pkg
//   Shared definitions for the debounce filter:
//     cell_state_t  - per-bit FSM encoding (ST_IDLE=1'b0, ST_COUNT=1'b1)
//     params_ok()   - elaboration-time sizing check: stable count >= 1 and
//                     the largest counter value (stable-1) fits in cnt_w bits
//   Optional feature macro used by the top level: DEBOUNCE_EVENT_EN.
// -----------------------------------------------------------------------------
package debounce_filter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } cell_state_t;

    function automatic bit params_ok(input int stable, input int cnt_w);
        longint max_cnt;
        longint cnt_range;
        if (stable < 1 || cnt_w < 1 || cnt_w > 62) begin
            return 1'b0;
        end
        max_cnt   = longint'(stable) - 64'sd1;
        cnt_range = 64'sd1 <<< cnt_w;
        return (max_cnt < cnt_range);
    endfunction

endpackage

// File: rtl/debounce_filter_cell.sv
// -----------------------------------------------------------------------------
// debounce_filter_cell
//   One-bit debounce filter: a 2-state FSM (IDLE/COUNT) plus a stability
//   counter. The filtered level flips only after the input has differed from
//   it for P_STABLE_CNT consecutive samples; any agreeing sample in between
//   restarts the count from zero.
// Ports
//   clk    in   1  clock, posedge
//   rst_n  in   1  asynchronous active-low reset
//   din    in   1  synchronized input bit
//   level  out  1  debounced level (registered)
//   rise   out  1  one-cycle pulse in the cycle level goes 0->1
//   fall   out  1  one-cycle pulse in the cycle level goes 1->0
//   state  out  1  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module debounce_filter_cell
    import debounce_filter_pkg::*;
#(
    parameter int   P_STABLE_CNT = 50000,
    parameter int   P_CNT_W      = 16,
    parameter logic P_RST_BIT    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic        level,
    output logic        rise,
    output logic        fall,
    output cell_state_t state
);

    localparam logic [P_CNT_W-1:0] CNT_MAX = P_CNT_W'(P_STABLE_CNT - 1);
    localparam logic [P_CNT_W-1:0] CNT_ONE = P_CNT_W'(1);

    cell_state_t        state_q, state_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               flip;

    // State register (also holds counter, level and pulse flops)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= P_RST_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic. cnt counts differing samples already seen; the sample
    // that makes it P_STABLE_CNT triggers the flip, so cnt never exceeds
    // P_STABLE_CNT-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flip    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (din != level_q) begin
                    if (P_STABLE_CNT == 1) begin
                        flip = 1'b1;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (din == level_q) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    flip    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: pulses are registered alongside the level so they
    // coincide with the cycle in which level shows its new value.
    always_comb begin
        level_d = level_q ^ flip;
        rise_d  = flip & ~level_q;
        fall_d  = flip & level_q;
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign state = state_q;

endmodule

// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
//   Per-bit glitch/bounce filter for already-synchronized slow inputs. Each
//   bit is an independent debounce_filter_cell; the top adds the optional
//   sticky event flags and interrupt.
//   Optional feature macro: DEBOUNCE_EVENT_EN (adds o_evt, i_evt_clr, o_irq).
// Ports
//   clk        in   1         clock, posedge
//   rst_n      in   1         asynchronous active-low reset
//   i_data     in   P_DATA_W  synchronized inputs
//   o_data     out  P_DATA_W  debounced levels (registered)
//   o_rise     out  P_DATA_W  one-cycle pulse on 0->1 of o_data[k]
//   o_fall     out  P_DATA_W  one-cycle pulse on 1->0 of o_data[k]
//   dbg_state  out  P_DATA_W  per-bit FSM state (1 = counting)
//   o_evt      out  P_DATA_W  sticky event flags           (DEBOUNCE_EVENT_EN)
//   i_evt_clr  in   P_DATA_W  write-1-to-clear for o_evt   (DEBOUNCE_EVENT_EN)
//   o_irq      out  1         registered OR of o_evt       (DEBOUNCE_EVENT_EN)
// -----------------------------------------------------------------------------
module debounce_filter
    import debounce_filter_pkg::*;
#(
    parameter int                  P_DATA_W     = 8,
    parameter int                  P_STABLE_CNT = 50000,
    parameter int                  P_CNT_W      = 16,
    parameter logic [P_DATA_W-1:0] P_RST_VAL    = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [P_DATA_W-1:0] i_data,
    output logic [P_DATA_W-1:0] o_data,
    output logic [P_DATA_W-1:0] o_rise,
    output logic [P_DATA_W-1:0] o_fall,
    output logic [P_DATA_W-1:0] dbg_state
`ifdef DEBOUNCE_EVENT_EN
    ,
    output logic [P_DATA_W-1:0] o_evt,
    input  logic [P_DATA_W-1:0] i_evt_clr,
    output logic                o_irq
`endif
);

    if (!params_ok(P_STABLE_CNT, P_CNT_W)) begin : g_bad_params
        $error("debounce_filter: need P_STABLE_CNT>=1 and P_STABLE_CNT-1 < 2**P_CNT_W");
    end

    for (genvar k = 0; k < P_DATA_W; k++) begin : g_cell
        cell_state_t cell_state;

        debounce_filter_cell #(
            .P_STABLE_CNT (P_STABLE_CNT),
            .P_CNT_W      (P_CNT_W),
            .P_RST_BIT    (P_RST_VAL[k])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (i_data[k]),
            .level (o_data[k]),
            .rise  (o_rise[k]),
            .fall  (o_fall[k]),
            .state (cell_state)
        );

        assign dbg_state[k] = (cell_state == ST_COUNT);
    end

`ifdef DEBOUNCE_EVENT_EN
    logic [P_DATA_W-1:0] evt_q;
    logic                irq_q;

    // Set has priority over clear so an edge landing on a clear is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            evt_q <= (evt_q & ~i_evt_clr) | o_rise | o_fall;
            irq_q <= |evt_q;
        end
    end

    assign o_evt = evt_q;
    assign o_irq = irq_q;
`endif

endmodule
